// File: rtl/demux_16_deser_if.sv
// Bundle between a serial bit producer / parallel word consumer and the
// demux_16_deser deserializer.
//
// Handshake rules: a bit transfers at a rising edge when in_valid and
// in_ready are both high (and clear is low); in_ready depends only on the
// deserializer state, never on in_valid. A word transfers at a rising edge
// when out_valid and out_ready are both high; out_word is held stable while
// out_valid is high and out_ready is low.
interface demux_16_deser_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
);
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;
  // Debug view of the deserializer FSM: 0 = FILL, 1 = HOLD.
  logic             fsm_state;

  modport master (
    output in_bit, in_valid, clear, out_ready,
    input  in_ready, idx, out_word, out_valid, fsm_state
  );

  modport slave (
    input  in_bit, in_valid, clear, out_ready,
    output in_ready, idx, out_word, out_valid, fsm_state
  );
endinterface

// File: rtl/demux_16_deser.sv
// Serial-to-parallel deserializer: steers each accepted bit into word
// position idx (or WIDTH-1-idx when MSB_FIRST), presents full words on a
// registered valid/ready output, and can hold one extra completed word.
module demux_16_deser #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_16_deser_if.slave  bus
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] out_word_r;
  logic             out_valid_r;

  logic [IDX_W-1:0] pos;
  logic [WIDTH-1:0] word_next;
  logic             last;
  logic             drain;
  logic             slot_free;

  assign pos       = (MSB_FIRST != 0) ? (IDX_W'(WIDTH - 1) - cnt) : cnt;
  assign last      = (cnt == IDX_W'(WIDTH - 1));
  assign drain     = out_valid_r & bus.out_ready;
  assign slot_free = ~out_valid_r | bus.out_ready;

  // Fill register with the incoming bit merged at its position.
  always_comb begin
    word_next      = fill;
    word_next[pos] = bus.in_bit;
  end

  // FSM, bit placement and output slot; reset wins, clear wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      cnt         <= '0;
      fill        <= '0;
      out_word_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      // A consumed word frees the slot unless a new word is loaded below.
      if (drain) out_valid_r <= 1'b0;
      case (state)
        FILL: begin
          if (bus.clear) begin
            cnt  <= '0;
            fill <= '0;
          end else if (bus.in_valid) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              if (slot_free) begin
                out_word_r  <= word_next;
                out_valid_r <= 1'b1;
                fill        <= '0;
              end else begin
                fill  <= word_next;
                state <= HOLD;
              end
            end else begin
              fill <= word_next;
            end
          end
        end
        HOLD: begin
          if (bus.clear) begin
            cnt   <= '0;
            fill  <= '0;
            state <= FILL;
          end else if (drain) begin
            out_word_r  <= fill;
            out_valid_r <= 1'b1;
            fill        <= '0;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = (state == FILL);
  assign bus.idx       = (state == HOLD) ? '0 : cnt;
  assign bus.out_word  = out_word_r;
  assign bus.out_valid = out_valid_r;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_demux_16_deser.sv
// Bench for demux_16_deser: an LSB-first and an MSB-first instance share one
// stimulus stream; a queue-level model predicts every cycle's outputs.
module tb_demux_16_deser;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic clear = 1'b0;
  logic out_ready = 1'b0;

  demux_16_deser_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus_l ();
  demux_16_deser_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus_m ();

  assign bus_l.in_bit    = in_bit;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.clear     = clear;
  assign bus_l.out_ready = out_ready;
  assign bus_m.in_bit    = in_bit;
  assign bus_m.in_valid  = in_valid;
  assign bus_m.clear     = clear;
  assign bus_m.out_ready = out_ready;

  demux_16_deser #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l.slave)
  );
  demux_16_deser #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bus_m.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // exp_q[0] is the word in the output slot, exp_q[1] a held word.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_qm[$];
  bit               bits[$];
  logic [WIDTH-1:0] last_l = '0;
  logic [WIDTH-1:0] last_m = '0;
  bit               model_live = 1'b0;
  int               pop_cnt = 0;

  always @(negedge clk) begin
    bit held, rdy, drn;
    logic [WIDTH-1:0] wl, wm;
    if (model_live && rst_n) begin
      chk("out_valid_l", bus_l.out_valid, exp_q.size() > 0);
      chk("out_valid_m", bus_m.out_valid, exp_qm.size() > 0);
      chk("out_word_l", bus_l.out_word, (exp_q.size() > 0) ? exp_q[0] : last_l);
      chk("out_word_m", bus_m.out_word, (exp_qm.size() > 0) ? exp_qm[0] : last_m);
      chk("in_ready", bus_l.in_ready, exp_q.size() < 2);
      chk("hold_state", bus_l.fsm_state, exp_q.size() == 2);
      chk("idx", bus_l.idx, bits.size());
    end
    if (!rst_n) begin
      exp_q.delete();
      exp_qm.delete();
      bits.delete();
      last_l = '0;
      last_m = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      held = (exp_q.size() == 2);
      rdy  = (exp_q.size() < 2);
      drn  = (exp_q.size() > 0) && out_ready;
      if (clear) begin
        bits.delete();
        if (held) begin
          void'(exp_q.pop_back());
          void'(exp_qm.pop_back());
        end
      end else if (in_valid && rdy) begin
        bits.push_back(in_bit);
        if (bits.size() == WIDTH) begin
          wl = '0;
          wm = '0;
          for (int k = 0; k < WIDTH; k++) begin
            wl = wl | (WIDTH'(bits[k]) << k);
            wm = wm | (WIDTH'(bits[k]) << (WIDTH - 1 - k));
          end
          exp_q.push_back(wl);
          exp_qm.push_back(wm);
          bits.delete();
        end
      end
      if (drn) begin
        last_l = exp_q.pop_front();
        last_m = exp_qm.pop_front();
        pop_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    bit rdy;
    int waited;
    in_valid = 1'b1;
    in_bit   = b;
    waited   = 0;
    do begin
      @(negedge clk);
      rdy = bus_l.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!rdy && waited < 200);
    if (!rdy) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int k = 0; k < WIDTH; k++) send_bit(w[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    logic [WIDTH-1:0] rw;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idx", bus_l.idx, 0);
    chk("rst_out_valid", bus_l.out_valid, 0);
    chk("rst_out_word", bus_l.out_word, 0);
    chk("rst_in_ready", bus_l.in_ready, 1);

    // Stream 1,0,1,1,0,0,0,0,1,1,1,1,0,1,0,1 == 16'hAF0D sent LSB first.
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(16'hAF0D);
    @(negedge clk);
    chk("t1_valid", bus_l.out_valid, 1);
    chk("t1_word_lsb", bus_l.out_word, 16'hAF0D);
    chk("t1_word_msb", bus_m.out_word, 16'hB0F5);
    chk("t1_idx", bus_l.idx, 0);
    @(negedge clk);
    chk("t1_pulse_end", bus_l.out_valid, 0);

    // Two words against a stalled consumer: second word is held.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_word(16'h1234);
    send_word(16'hFFFF);
    @(negedge clk);
    chk("t3_hold_word", bus_l.out_word, 16'h1234);
    chk("t3_hold_in_ready", bus_l.in_ready, 0);
    chk("t3_hold_state", bus_l.fsm_state, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_next_word", bus_l.out_word, 16'hFFFF);
    chk("t3_next_valid", bus_l.out_valid, 1);
    chk("t3_in_ready", bus_l.in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(2);

    // Abort after 7 bits, then a clean word.
    for (int k = 0; k < 7; k++) send_bit(1'($urandom_range(0, 1)));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    send_word(16'h00FF);
    @(negedge clk);
    chk("t4_word", bus_l.out_word, 16'h00FF);
    chk("t4_valid", bus_l.out_valid, 1);
    idle(2);

    // Back-to-back words, consumer always ready.
    p0 = pop_cnt;
    for (int w = 0; w < 4; w++) send_word(WIDTH'($urandom));
    idle(2);
    chk("t5_words", pop_cnt - p0, 4);

    // Reset mid-word with a word presented.
    out_ready = 1'b0;
    send_word(WIDTH'($urandom));
    for (int k = 0; k < 9; k++) send_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    chk("t6_idx_before", bus_l.idx, 9);
    chk("t6_valid_before", bus_l.out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idx", bus_l.idx, 0);
    chk("t6_valid", bus_l.out_valid, 0);
    chk("t6_word", bus_l.out_word, 0);
    chk("t6_in_ready", bus_l.in_ready, 1);

    // Randomized traffic with stalls and sparse clears.
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom_range(0, 1));
      out_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 7) != 0)
                                       : ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 99) == 0);
      rw        = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
